// File: rtl/dsd_cache_pkg.sv
// Shared cache definitions: block/word geometry, cache FSM encoding and word helpers.
// Both the d-side and i-side L1 caches use this package.
package dsd_cache_pkg;

  localparam int BLK_W   = 128;
  localparam int WORD_W  = 32;
  localparam int BADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    ALLOCATE,
    FILL
  } cache_state_t;

  // Extract word 'off' from a block; word 0 sits in the low bits.
  function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                 input logic [1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

  // Return the block with word 'off' replaced by 'word'.
  function automatic logic [BLK_W-1:0] blk_merge(input logic [BLK_W-1:0] blk,
                                                 input logic [1:0] off,
                                                 input logic [WORD_W-1:0] word);
    logic [BLK_W-1:0] res;
    res = blk;
    res[off*WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// Processor data port and L2 d-side port of the L1 data cache.
// The cache uses the slave modport; the processor/L2 side uses master.
interface l1_dcache_if
  import dsd_cache_pkg::*;
#(
  parameter int PADDR_W = 30
);
  logic               proc_read;
  logic               proc_write;
  logic [PADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0]  proc_wdata;
  logic [WORD_W-1:0]  proc_rdata;
  logic               proc_stall;
  logic               l2_read;
  logic               l2_write;
  logic [PADDR_W-3:0] l2_addr;
  logic [BLK_W-1:0]   l2_wdata;
  logic [BLK_W-1:0]   l2_rdata;
  logic               l2_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, l2_rdata, l2_ready,
    output proc_rdata, proc_stall, l2_read, l2_write, l2_addr, l2_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, l2_rdata, l2_ready,
    input  proc_rdata, proc_stall, l2_read, l2_write, l2_addr, l2_wdata
  );

endinterface

// File: rtl/l1_dcache_tag_array.sv
// Valid/dirty/tag storage for a direct-mapped cache with a combinational
// lookup of the indexed entry. Valid and dirty reset asynchronously; tags do
// not need a reset because they are qualified by valid.
module l1_tag_array #(
  parameter int NUM_BLK = 8,
  parameter int TAG_W   = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NUM_BLK)-1:0] idx,
  input  logic [TAG_W-1:0]           tag,
  input  logic                       fill_en,
  input  logic                       dirty_set,
  output logic                       hit,
  output logic                       blk_valid,
  output logic                       blk_dirty,
  output logic [TAG_W-1:0]           blk_tag
);

  logic [NUM_BLK-1:0] valid_q;
  logic [NUM_BLK-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_mem [NUM_BLK];

  // Status bits: a fill makes the entry valid and clean, a write hit marks it dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (dirty_set) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag storage, written only when a new block is installed.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx] <= tag;
    end
  end

  assign blk_valid = valid_q[idx];
  assign blk_dirty = dirty_q[idx];
  assign blk_tag   = tag_mem[idx];
  assign hit       = blk_valid && (blk_tag == tag);

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Hits complete in
// the request cycle; misses stall the processor while the victim is written
// back (if dirty) and the block is fetched from L2. All L2-side outputs are
// registered so there is no combinational path from the processor to L2.
module l1_dcache
  import dsd_cache_pkg::*;
#(
  parameter int NUM_BLK = 8,
  parameter int PADDR_W = 30
) (
  input  logic       clk,
  input  logic       proc_reset,
  l1_dcache_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_BLK);
  localparam int BA_W  = PADDR_W - 2;
  localparam int TAG_W = BA_W - IDX_W;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic             req;
  logic             hit;
  logic             blk_valid;
  logic             blk_dirty;
  logic [TAG_W-1:0] blk_tag;
  logic             fill_en;
  logic             wr_hit;

  cache_state_t state_q;
  cache_state_t state_d;

  logic [BLK_W-1:0] data_mem [NUM_BLK];

  logic             l2_read_q;
  logic             l2_write_q;
  logic [BA_W-1:0]  l2_addr_q;
  logic [BLK_W-1:0] l2_wdata_q;

  assign idx = bus.proc_addr[IDX_W+1:2];
  assign tag = bus.proc_addr[PADDR_W-1:IDX_W+2];
  assign off = bus.proc_addr[1:0];
  assign req = bus.proc_read | bus.proc_write;

  l1_tag_array #(
    .NUM_BLK(NUM_BLK),
    .TAG_W  (TAG_W)
  ) u_tags (
    .clk      (clk),
    .rst      (proc_reset),
    .idx      (idx),
    .tag      (tag),
    .fill_en  (fill_en),
    .dirty_set(wr_hit),
    .hit      (hit),
    .blk_valid(blk_valid),
    .blk_dirty(blk_dirty),
    .blk_tag  (blk_tag)
  );

  // Stall is held low during reset so an aborted miss releases the processor at once.
  assign bus.proc_stall = req & ~proc_reset & ~((state_q == IDLE) & hit);
  // Invalid blocks read as zero, which also gives a defined value out of reset.
  assign bus.proc_rdata = blk_valid ? blk_word(data_mem[idx], off) : '0;

  // Miss-handling state register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus fill and write-hit strobes; l2_ready outside WRITE_BACK/ALLOCATE is ignored.
  always_comb begin
    state_d = state_q;
    fill_en = 1'b0;
    wr_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            wr_hit = bus.proc_write;
          end else if (blk_dirty) begin
            state_d = WRITE_BACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        if (bus.l2_ready) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.l2_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data array: whole-block install on fill, single-word merge on a write hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[idx] <= bus.l2_rdata;
    end else if (wr_hit) begin
      data_mem[idx] <= blk_merge(data_mem[idx], off, bus.proc_wdata);
    end
  end

  // L2 request registers follow the next state, so requests drop the cycle after l2_ready.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
    end else begin
      l2_read_q  <= (state_d == ALLOCATE);
      l2_write_q <= (state_d == WRITE_BACK);
      if ((state_q == IDLE) && (state_d == WRITE_BACK)) begin
        l2_addr_q  <= {blk_tag, idx};
        l2_wdata_q <= data_mem[idx];
      end else if ((state_q != ALLOCATE) && (state_d == ALLOCATE)) begin
        l2_addr_q  <= bus.proc_addr[PADDR_W-1:2];
      end
    end
  end

  assign bus.l2_read  = l2_read_q;
  assign bus.l2_write = l2_write_q;
  assign bus.l2_addr  = l2_addr_q;
  assign bus.l2_wdata = l2_wdata_q;

endmodule

// File: tb/tb_l1_dcache.sv
// Bench for l1_dcache: a reference cache/memory model predicts read data and
// the L2 transactions each access must cause; a 4-cycle L2 model answers them.
module tb_l1_dcache;
  import dsd_cache_pkg::*;

  localparam int L2_LAT = 4;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } l2_txn_t;

  logic clk = 1'b0;
  logic proc_reset;

  l1_dcache_if bus ();

  l1_dcache dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  l2_txn_t      exp_l2 [$];
  logic [31:0]  exp_rd [$];
  logic [127:0] l2_mem [logic [27:0]];
  logic [31:0]  wr_ref [logic [29:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] init_blk(input logic [27:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hA500_0000 ^ {2'b00, b, 2'(k)};
    return r;
  endfunction

  function automatic logic [127:0] l2_blk(input logic [27:0] b);
    if (l2_mem.exists(b)) return l2_mem[b];
    return init_blk(b);
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    logic [127:0] blk;
    if (wr_ref.exists(a)) return wr_ref[a];
    blk = l2_blk(a[29:2]);
    return blk[a[1:0]*32 +: 32];
  endfunction

  function automatic logic [127:0] ref_block(input logic [27:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = ref_word({b, 2'(k)});
    return r;
  endfunction

  // Update the reference cache state and queue the L2 traffic this access must produce.
  task automatic model_access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                              output bit miss);
    logic [2:0]  i;
    logic [24:0] t;
    l2_txn_t     e;
    i = a[4:2];
    t = a[29:5];
    miss = !(m_valid[i] && m_tag[i] == t);
    if (miss) begin
      if (m_dirty[i]) begin
        e.wr = 1'b1; e.addr = {m_tag[i], i}; e.data = ref_block({m_tag[i], i});
        exp_l2.push_back(e);
      end
      e.wr = 1'b0; e.addr = a[29:2]; e.data = '0;
      exp_l2.push_back(e);
      m_valid[i] = 1'b1; m_tag[i] = t; m_dirty[i] = 1'b0;
    end
    if (wr) begin
      wr_ref[a] = d;
      m_dirty[i] = 1'b1;
    end
  endtask

  task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                        input string nm);
    bit          miss;
    bit          done;
    logic [31:0] e;
    model_access(wr, a, d, miss);
    if (!wr) exp_rd.push_back(ref_word(a));
    @(posedge clk); #1;
    bus.proc_addr  = a;
    bus.proc_wdata = d;
    bus.proc_read  = !wr;
    bus.proc_write = wr;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (c == 0) chk({nm, "_stall"}, 128'(bus.proc_stall), 128'(miss));
      if (!bus.proc_stall) begin
        done = 1'b1;
        if (!wr) begin
          e = exp_rd.pop_front();
          chk({nm, "_rdata"}, 128'(bus.proc_rdata), 128'(e));
        end
      end
    end
    if (!done) chk({nm, "_timeout"}, 128'(0), 128'(1));
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  // L2 model: pops the expected transaction when a request appears, answers after L2_LAT cycles.
  initial begin
    l2_txn_t      e;
    bit           w;
    logic [27:0]  ad;
    logic [127:0] wd;
    bus.l2_ready = 1'b0;
    bus.l2_rdata = '0;
    forever begin
      @(negedge clk);
      if (!proc_reset && (bus.l2_read || bus.l2_write)) begin
        chk("l2_excl", 128'(bus.l2_read & bus.l2_write), 128'(0));
        w  = bus.l2_write;
        ad = bus.l2_addr;
        wd = bus.l2_wdata;
        if (exp_l2.size() == 0) begin
          chk("l2_unexpected", 128'(1), 128'(0));
        end else begin
          e = exp_l2.pop_front();
          chk("l2_op", 128'(w), 128'(e.wr));
          chk("l2_addr", 128'(ad), 128'(e.addr));
          if (w) chk("l2_wdata", wd, e.data);
        end
        repeat (L2_LAT - 1) @(negedge clk);
        bus.l2_ready = 1'b1;
        if (w) l2_mem[ad] = wd;
        @(negedge clk);
        bus.l2_ready = 1'b0;
        if (w) chk("l2_write_drop", 128'(bus.l2_write), 128'(0));
        else begin
          chk("l2_read_drop", 128'(bus.l2_read), 128'(0));
          bus.l2_rdata = l2_blk(ad);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          miss;
    logic [29:0] ra;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    proc_reset     = 1'b1;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
    #1;
    chk("rst_stall", 128'(bus.proc_stall), 128'(0));
    chk("rst_l2_read", 128'(bus.l2_read), 128'(0));
    chk("rst_l2_write", 128'(bus.l2_write), 128'(0));
    chk("rst_l2_addr", 128'(bus.l2_addr), 128'(0));
    chk("rst_l2_wdata", bus.l2_wdata, 128'(0));
    chk("rst_rdata", 128'(bus.proc_rdata), 128'(0));
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;

    // cold miss, then hits, then write hit
    access(0, 30'h10, 32'h0, "t1_cold");
    access(0, 30'h11, 32'h0, "t2_hit");
    access(1, 30'h12, 32'hDEADBEEF, "t3_wr");
    access(0, 30'h12, 32'h0, "t3_rd");
    // dirty eviction of block 0x4
    access(0, 30'h32, 32'h0, "t4_evict");
    access(0, 30'h12, 32'h0, "t4_back");
    // write miss to clean idx, then evict it
    access(1, 30'h21, 32'h12345678, "t5_wmiss");
    access(0, 30'h21, 32'h0, "t5_rd");
    access(0, 30'h41, 32'h0, "t5_evict");
    access(0, 30'h21, 32'h0, "t5_back");

    // reset during ALLOCATE
    model_access(0, 30'h70, 32'h0, miss);
    @(posedge clk); #1;
    bus.proc_addr = 30'h70;
    bus.proc_read = 1'b1;
    for (int c = 0; c < 60 && !bus.l2_read; c++) @(negedge clk);
    chk("t6_l2read_seen", 128'(bus.l2_read), 128'(1));
    #2 proc_reset = 1'b1;
    #1;
    chk("t6_l2read", 128'(bus.l2_read), 128'(0));
    chk("t6_stall", 128'(bus.proc_stall), 128'(0));
    chk("t6_l2write", 128'(bus.l2_write), 128'(0));
    chk("t6_rdata", 128'(bus.proc_rdata), 128'(0));
    bus.proc_read = 1'b0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    wr_ref.delete();
    repeat (8) @(negedge clk);
    proc_reset = 1'b0;
    access(0, 30'h70, 32'h0, "t6_again");

    // mixed traffic over a small address set to force conflicts and evictions
    for (int n = 0; n < 30; n++) begin
      ra = 30'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) access(1, ra, $urandom, "rnd_wr");
      else access(0, ra, 32'h0, "rnd_rd");
    end

    repeat (4) @(negedge clk);
    chk("l2_left", 128'(exp_l2.size()), 128'(0));
    chk("rd_left", 128'(exp_rd.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
